// File: rtl/sub32_sat_pipe.sv
// Two-stage pipelined 32-bit saturating subtractor with valid/ready flow control,
// tag passthrough and saturation status (sticky flag + saturating event counter).
module sub32_sat_pipe #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      src0,
  input  logic [31:0]      src1,
  input  logic             sign_s0,
  input  logic             sign_s1,
  input  logic             i_sign_d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      dst,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             stat_clr
);

  localparam int unsigned DW = 32;

  logic             s1_valid;
  logic [DW:0]      s1_diff;
  logic             s1_signed;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             xfer;
  logic             is_signed_c;
  logic [DW:0]      ext0_c;
  logic [DW:0]      ext1_c;
  logic [DW-1:0]    sat_dst_c;
  logic             sat_flag_c;

  // Handshake: in_ready depends on out_ready only, never on in_valid
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Operand extension to 33 bits
  always_comb begin
    is_signed_c = sign_s0 | sign_s1 | i_sign_d;
    ext0_c      = is_signed_c ? {src0[DW-1], src0} : {1'b0, src0};
    ext1_c      = is_signed_c ? {src1[DW-1], src1} : {1'b0, src1};
  end

  // Clamp the stage-1 difference into the destination range
  always_comb begin
    sat_dst_c  = s1_diff[DW-1:0];
    sat_flag_c = 1'b0;
    if (s1_signed) begin
      if (s1_diff[DW] != s1_diff[DW-1]) begin
        sat_flag_c = 1'b1;
        sat_dst_c  = s1_diff[DW] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (s1_diff[DW]) begin
      sat_flag_c = 1'b1;
      sat_dst_c  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_diff   <= ext0_c - ext1_c;
      s1_signed <= is_signed_c;
      s1_tag    <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dst       <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_adv) begin
        dst     <= sat_dst_c;
        out_tag <= s1_tag;
        out_sat <= sat_flag_c;
      end
    end
  end

  // Status updates only on an accepted result; clear has priority
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      sat_sticky <= 1'b0;
      sat_cnt    <= '0;
    end else if (xfer && out_sat) begin
      sat_sticky <= 1'b1;
      if (sat_cnt != {CNT_W{1'b1}}) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
